// File: rtl/mem_wb_skid_buffer.sv
// Two-entry skid buffer sitting between the MEM and WB pipeline stages.
// The head entry drives every out_* field straight from registers, so no
// combinational path exists from in_* to out_*. The skid entry catches the
// beat that arrives while the head is stalled. in_ready is registered.
//
// Handshake: a beat moves on a port only in a cycle where valid and ready are
// both high at the rising edge. in_ready does not depend on in_valid, and
// out_valid does not depend on out_ready. Once offered, out_* stays stable
// until popped.
//
// count carries the FSM state encoding directly (EMPTY=0, ONE=1, FULL=2), so
// it doubles as the debug view of the state register.
module mem_wb_skid_buffer #(
  parameter int DATA_W        = 64,
  parameter int RD_W          = 5,
  parameter int ZERO_REG_GATE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic [DATA_W-1:0] in_read_data,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_mem_to_reg,
  input  logic              in_reg_write,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [DATA_W-1:0] out_read_data,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_mem_to_reg,
  output logic              out_reg_write,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_en,
  output logic [1:0]        count
);

  localparam int ENT_W = 2 * DATA_W + RD_W + 2;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic               r_in_ready;
  logic [ENT_W-1:0]   r_head;
  logic [ENT_W-1:0]   r_skid;
  logic [ENT_W-1:0]   w_in_entry;
  logic               w_accept;
  logic               w_pop;
  logic               w_load_head_in;
  logic               w_load_head_skid;
  logic               w_load_skid;
  logic               w_rd_ok;

  // Entry layout: {mem_to_reg, reg_write, rd, read_data, result}.
  assign w_in_entry = {in_mem_to_reg, in_reg_write, in_rd, in_read_data, in_result};

  assign w_accept = in_valid & r_in_ready;
  assign w_pop    = out_valid & out_ready;

  // Next-state and load selects; flush overrides every transition.
  always_comb begin
    w_next_state     = r_state;
    w_load_head_in   = 1'b0;
    w_load_head_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (flush) begin
      w_next_state = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            w_next_state   = S_ONE;
            w_load_head_in = 1'b1;
          end
        end
        S_ONE: begin
          case ({w_accept, w_pop})
            2'b11: w_load_head_in = 1'b1;
            2'b01: w_next_state = S_EMPTY;
            2'b10: begin
              w_next_state = S_FULL;
              w_load_skid  = 1'b1;
            end
            default: w_next_state = S_ONE;
          endcase
        end
        S_FULL: begin
          if (w_pop) begin
            w_next_state     = S_ONE;
            w_load_head_skid = 1'b1;
          end
        end
        default: w_next_state = S_EMPTY;
      endcase
    end
  end

  // State register and the registered ready that mirrors "not FULL".
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_next_state;
      r_in_ready <= (w_next_state != S_FULL);
    end
  end

  // Payload storage; flush and reset both wipe the entries.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head <= '0;
      r_skid <= '0;
    end else if (flush) begin
      r_head <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_head_in) begin
        r_head <= w_in_entry;
      end else if (w_load_head_skid) begin
        r_head <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_in_entry;
      end
    end
  end

  assign {out_mem_to_reg, out_reg_write, out_rd, out_read_data, out_result} = r_head;

  assign in_ready  = r_in_ready;
  assign out_valid = (r_state != S_EMPTY);
  assign count     = r_state;
  assign wb_data   = out_mem_to_reg ? out_read_data : out_result;

  // Register x0 is hardwired, so its writes can optionally be dropped here.
  assign w_rd_ok = (ZERO_REG_GATE == 0) || (out_rd != '0);
  assign wb_en   = w_pop & out_reg_write & ~flush & w_rd_ok;

endmodule

// File: tb/tb_mem_wb_skid_buffer.sv
// Bench for mem_wb_skid_buffer: two instances (x0 gating on and off) share one
// stimulus stream; an in-order queue model predicts every output each cycle.
module tb_mem_wb_skid_buffer;

  localparam int DW = 32;
  localparam int RW = 6;
  localparam int EW = 2 * DW + RW + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          flush, in_valid, in_mem_to_reg, in_reg_write, out_ready;
  logic [DW-1:0] in_result, in_read_data;
  logic [RW-1:0] in_rd;

  logic          in_ready, out_valid, out_mem_to_reg, out_reg_write, wb_en;
  logic [DW-1:0] out_result, out_read_data, wb_data;
  logic [RW-1:0] out_rd;
  logic [1:0]    count;

  logic          in_ready0, out_valid0, out_mem_to_reg0, out_reg_write0, wb_en0;
  logic [DW-1:0] out_result0, out_read_data0, wb_data0;
  logic [RW-1:0] out_rd0;
  logic [1:0]    count0;

  mem_wb_skid_buffer #(.DATA_W(DW), .RD_W(RW), .ZERO_REG_GATE(1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_read_data(in_read_data), .in_rd(in_rd),
    .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_read_data(out_read_data), .out_rd(out_rd),
    .out_mem_to_reg(out_mem_to_reg), .out_reg_write(out_reg_write),
    .wb_data(wb_data), .wb_en(wb_en), .count(count)
  );

  mem_wb_skid_buffer #(.DATA_W(DW), .RD_W(RW), .ZERO_REG_GATE(0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0),
    .in_result(in_result), .in_read_data(in_read_data), .in_rd(in_rd),
    .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write),
    .out_valid(out_valid0), .out_ready(out_ready),
    .out_result(out_result0), .out_read_data(out_read_data0), .out_rd(out_rd0),
    .out_mem_to_reg(out_mem_to_reg0), .out_reg_write(out_reg_write0),
    .wb_data(wb_data0), .wb_en(wb_en0), .count(count0)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Beat as the model stores it: {mem_to_reg, reg_write, rd, read_data, result}.
  function automatic logic [EW-1:0] mk(input logic m2r, input logic rw,
                                       input logic [RW-1:0] rd,
                                       input logic [DW-1:0] rdata,
                                       input logic [DW-1:0] res);
    return {m2r, rw, rd, rdata, res};
  endfunction

  // Compare outputs of the current cycle against the queue, then advance the
  // queue by what the coming edge does.
  task automatic model_step();
    int            sz;
    logic [EW-1:0] h;
    logic          h_m2r, h_rw, pop, acc, exp_we, exp_we0;
    logic [RW-1:0] h_rd;
    logic [DW-1:0] h_res, h_rdata;
    sz = exp_q.size();
    check("count", 64'(count), 64'(sz));
    check("count0", 64'(count0), 64'(sz));
    check("out_valid", 64'(out_valid), 64'(sz != 0));
    check("in_ready", 64'(in_ready), 64'(sz < 2));
    check("in_ready0", 64'(in_ready0), 64'(sz < 2));
    pop = (sz != 0) && out_ready;
    exp_we = 1'b0;
    exp_we0 = 1'b0;
    if (sz != 0) begin
      h       = exp_q[0];
      h_res   = h[DW-1:0];
      h_rdata = h[2*DW-1:DW];
      h_rd    = h[2*DW+RW-1:2*DW];
      h_rw    = h[EW-2];
      h_m2r   = h[EW-1];
      check("out_result", 64'(out_result), 64'(h_res));
      check("out_read_data", 64'(out_read_data), 64'(h_rdata));
      check("out_rd", 64'(out_rd), 64'(h_rd));
      check("out_ctrl", 64'({out_mem_to_reg, out_reg_write}), 64'({h_m2r, h_rw}));
      check("wb_data", 64'(wb_data), 64'(h_m2r ? h_rdata : h_res));
      check("out_result0", 64'(out_result0), 64'(h_res));
      exp_we0 = out_ready && h_rw && !flush;
      exp_we  = exp_we0 && (h_rd != 0);
    end
    check("wb_en", 64'(wb_en), 64'(exp_we));
    check("wb_en0", 64'(wb_en0), 64'(exp_we0));
    acc = in_valid && (sz < 2);
    if (flush) begin
      exp_q.delete();
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(mk(in_mem_to_reg, in_reg_write, in_rd, in_read_data, in_result));
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_cycle(input logic v, input logic r, input logic f,
                             input logic [DW-1:0] res, input logic [DW-1:0] rdata,
                             input logic [RW-1:0] rd, input logic m2r, input logic rw);
    @(negedge clk);
    in_valid      = v;
    out_ready     = r;
    flush         = f;
    in_result     = res;
    in_read_data  = rdata;
    in_rd         = rd;
    in_mem_to_reg = m2r;
    in_reg_write  = rw;
    #1;
    model_step();
  endtask

  task automatic idle(input logic r);
    drive_cycle(1'b0, r, 1'b0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_count"}, 64'(count), 64'd0);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_wb_en"}, 64'(wb_en), 64'd0);
    check({tag, "_wb_en0"}, 64'(wb_en0), 64'd0);
    check({tag, "_out_result"}, 64'(out_result), 64'd0);
    check({tag, "_out_rd"}, 64'(out_rd), 64'd0);
    check({tag, "_wb_data"}, 64'(wb_data), 64'd0);
  endtask

  int rdy_pct [4] = '{90, 50, 15, 100};
  int val_pct [4] = '{60, 95, 40, 100};

  initial begin
    flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    in_result = 32'hdead; in_read_data = 32'hbeef; in_rd = 6'd7;
    in_mem_to_reg = 1'b0; in_reg_write = 1'b1;

    // Reset held: offered beats are ignored, everything reads zero.
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_reset_outputs("rst");
    in_valid = 1'b0;
    reset = 1'b1;

    // First beat: one-cycle latency and an immediate write strobe.
    drive_cycle(1'b1, 1'b1, 1'b0, 32'h11, 32'h0, 6'd3, 1'b0, 1'b1);
    idle(1'b1);
    check("t1_out_valid", 64'(out_valid), 64'd1);
    check("t1_out_result", 64'(out_result), 64'h11);
    check("t1_wb_en", 64'(wb_en), 64'd1);
    check("t1_count", 64'(count), 64'd1);
    idle(1'b1);

    // Backpressure: A, B fill; C refused while FULL; then drain in order.
    drive_cycle(1'b1, 1'b0, 1'b0, 32'hA, 32'h0, 6'd1, 1'b0, 1'b1);
    drive_cycle(1'b1, 1'b0, 1'b0, 32'hB, 32'h0, 6'd2, 1'b0, 1'b1);
    drive_cycle(1'b1, 1'b0, 1'b0, 32'hC, 32'h0, 6'd4, 1'b0, 1'b1);
    check("full_count", 64'(count), 64'd2);
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_head", 64'(out_result), 64'hA);
    drive_cycle(1'b1, 1'b0, 1'b0, 32'hC, 32'h0, 6'd4, 1'b0, 1'b1);
    check("hold_head", 64'(out_result), 64'hA);
    drive_cycle(1'b1, 1'b1, 1'b0, 32'hC, 32'h0, 6'd4, 1'b0, 1'b1);
    check("drain_a", 64'(out_result), 64'hA);
    drive_cycle(1'b1, 1'b1, 1'b0, 32'hC, 32'h0, 6'd4, 1'b0, 1'b1);
    check("drain_b", 64'(out_result), 64'hB);
    idle(1'b1);
    check("drain_c", 64'(out_result), 64'hC);
    idle(1'b1);
    check("drained_count", 64'(count), 64'd0);

    // Writeback mux selection.
    drive_cycle(1'b1, 1'b1, 1'b0, 32'h1234, 32'h5555, 6'd5, 1'b1, 1'b1);
    drive_cycle(1'b1, 1'b1, 1'b0, 32'h1234, 32'h5555, 6'd5, 1'b0, 1'b1);
    check("wb_sel_mem", 64'(wb_data), 64'h5555);
    idle(1'b1);
    check("wb_sel_alu", 64'(wb_data), 64'h1234);

    // Writes to x0 with and without gating.
    drive_cycle(1'b1, 1'b1, 1'b0, 32'h77, 32'h0, 6'd0, 1'b0, 1'b1);
    idle(1'b1);
    check("x0_gated", 64'(wb_en), 64'd0);
    check("x0_ungated", 64'(wb_en0), 64'd1);

    // Flush from FULL with a beat offered: dropped, no write strobe.
    drive_cycle(1'b1, 1'b0, 1'b0, 32'h21, 32'h0, 6'd9, 1'b0, 1'b1);
    drive_cycle(1'b1, 1'b0, 1'b0, 32'h22, 32'h0, 6'd9, 1'b0, 1'b1);
    drive_cycle(1'b1, 1'b1, 1'b1, 32'h23, 32'h0, 6'd9, 1'b0, 1'b1);
    check("flush_wb_en", 64'(wb_en), 64'd0);
    check("flush_wb_en0", 64'(wb_en0), 64'd0);
    idle(1'b1);
    check("flush_count", 64'(count), 64'd0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);

    // Asynchronous reset in the middle of a pop from FULL.
    drive_cycle(1'b1, 1'b0, 1'b0, 32'h31, 32'h0, 6'd9, 1'b0, 1'b1);
    drive_cycle(1'b1, 1'b0, 1'b0, 32'h32, 32'h0, 6'd9, 1'b0, 1'b1);
    drive_cycle(1'b1, 1'b1, 1'b0, 32'h33, 32'h0, 6'd9, 1'b0, 1'b1);
    reset = 1'b0;
    #1;
    check_reset_outputs("async");
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;

    // Randomized traffic in phases of differing pressure.
    for (int p = 0; p < 10000; p++) begin
      int ph;
      logic v, r, f;
      ph = (p / 500) % 4;
      v = ($urandom_range(0, 99) < val_pct[ph]);
      r = ($urandom_range(0, 99) < rdy_pct[ph]);
      f = ($urandom_range(0, 59) == 0);
      drive_cycle(v, r, f, $urandom(), $urandom(), 6'($urandom_range(0, 63)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 8));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
